// File: rtl/arith_pkg.sv
// Shared arithmetic definitions.
// FSM state encoding and default operand width.
package arith_pkg;

  localparam int ARITH_WIDTH = 8;

  // 2'd3 is never entered; decoders treat it as idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ILL  = 2'd3
  } state_t;

endpackage

// File: rtl/carry_lookahead_adder.sv
// WIDTH-bit carry lookahead adder.
// Ports: a, b, carry_in -> sum, carry_out.
module carry_lookahead_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  // Each carry is expanded from g/p and carry_in.
  always_comb begin
    logic cc;
    cc = 1'b0;
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    c[0] = carry_in;
    for (int i = 0; i < WIDTH; i++) begin
      cc = carry_in;
      for (int j = 0; j <= i; j++) begin
        cc = g[j] | (p[j] & cc);
      end
      c[i+1] = cc;
    end
  end

  assign sum       = p ^ c[WIDTH-1:0];
  assign carry_out = c[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier, one bit per clock.
// Ports: start_valid/ready+a,b in; result_valid/ready+product out; busy.
module shift_add_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t             state_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      cnt_r;

  logic             st_idle;
  logic             st_run;
  logic             st_done;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;

  assign st_idle = (state_r == ST_IDLE) ||
                   (state_r == ST_ILL);
  assign st_run  = (state_r == ST_RUN);
  assign st_done = (state_r == ST_DONE);

  assign addend = acc_r[0] ? mcand_r : '0;

  carry_lookahead_adder #(
    .WIDTH(WIDTH)
  ) u_cla (
    .a         (acc_r[2*WIDTH-1:WIDTH]),
    .b         (addend),
    .carry_in  (1'b0),
    .sum       (sum),
    .carry_out (cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      mcand_r <= '0;
      acc_r   <= '0;
      cnt_r   <= '0;
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (start_valid) begin
            state_r <= ST_RUN;
            mcand_r <= a;
            acc_r   <= {{WIDTH{1'b0}}, b};
            cnt_r   <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        st_run: begin
          // Carry lands in the top bit as the pair shifts right.
          acc_r <= {cout, sum, acc_r[WIDTH-1:1]};
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_DONE;
          end
        end
        st_done: begin
          if (result_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign start_ready  = st_idle;
  assign result_valid = st_done;
  assign busy         = st_run | st_done;
  assign product      = acc_r;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier.
// Random and directed operands against a*b.
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start_valid;
  logic           start_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           result_valid;
  logic           result_ready = 1'b0;
  logic [2*W-1:0] product;
  logic           busy;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] prod;
    int             acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   gap_target = 0;
  int   wait_cnt = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  // Consumer: hold ready low gap_target cycles of DONE.
  always @(negedge clk) begin
    if (result_valid) begin
      if (wait_cnt < gap_target) begin
        result_ready = 1'b0;
        wait_cnt++;
      end else begin
        result_ready = 1'b1;
      end
    end else begin
      wait_cnt = 0;
      result_ready = 1'($urandom_range(0, 1));
    end
  end

  bit outstanding = 0;
  bit seen = 0;
  bit prev_hs = 0;
  bit prev_bp = 0;

  // Monitor: samples just after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      outstanding = 0;
      seen = 0;
      prev_hs = 0;
      prev_bp = 0;
    end else begin
      if (prev_hs)
        chk("idle_after_hs",
            {30'd0, result_valid, start_ready}, 32'd1);
      if (prev_bp)
        chk("valid_held", {31'd0, result_valid}, 32'd1);
      chk("start_ready", {31'd0, start_ready},
          {31'd0, !outstanding});
      if (start_valid && start_ready) outstanding = 1;
      if (result_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual=%h required=none",
                   product);
        end else begin
          if (!seen) begin
            chk("latency", cyc - sb[0].acc, 32'd8);
            seen = 1;
          end
          chk("product", {16'd0, product},
              {16'd0, sb[0].prod});
          if (result_ready) begin
            void'(sb.pop_front());
            seen = 0;
          end
        end
        if (result_ready) outstanding = 0;
      end
      prev_hs = result_valid && result_ready;
      prev_bp = result_valid && !result_ready;
    end
  end

  task automatic issue(logic [W-1:0] x, logic [W-1:0] y,
                       int gap, bit push, bit jam);
    int n;
    n = 0;
    while (!start_ready) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=0 required=1");
        return;
      end
    end
    gap_target = gap;
    a = x;
    b = y;
    start_valid = 1'b1;
    if (push) sb.push_back('{x * y, cyc + 1});
    @(negedge clk);
    start_valid = 1'b0;
    if (jam) begin
      while (busy && !result_valid) begin
        a = W'($urandom);
        b = W'($urandom);
        start_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      start_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0",
               sb.size());
    end
  endtask

  task automatic reset_vals();
    chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start_valid = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'hFF, 8'hFF, 0, 1, 0);
    issue(8'h00, 8'hA5, 0, 1, 0);
    issue(8'hA5, 8'h01, 0, 1, 0);
    issue(8'h01, 8'h80, 0, 1, 0);
    issue(8'h12, 8'h34, 5, 1, 0);
    issue(8'hC3, 8'h5A, 1, 1, 1);
    drain();

    // Abort 0x80*0x80 at its fourth iteration.
    issue(8'h80, 8'h80, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_vals();
    repeat (14) @(negedge clk);
    issue(8'h80, 8'h80, 0, 1, 0);
    drain();

    for (int i = 0; i < 1000; i++) begin
      issue(W'($urandom), W'($urandom),
            $urandom_range(0, 3), 1,
            1'($urandom_range(0, 1)));
    end
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
